// File: rtl/xpb_lut_bank_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : xpb_pkg
//  Purpose  : Shared definitions for the runtime-loadable XPB lookup bank:
//             default geometry, summed-output width helper and FSM encoding.
//  Ports    : none (package)
//  Revision : 1.0  initial release
// ============================================================================
package xpb_pkg;

    localparam int XPB_WORD_BITS  = 1024;
    localparam int XPB_IDX_BITS   = 5;
    localparam int XPB_NUM_TABLES = 4;

    // Bank state: tables are either being streamed in, or complete and usable.
    typedef enum logic [0:0] {
        ST_LOAD  = 1'b0,
        ST_READY = 1'b1
    } xpb_state_t;

    // Width that holds the unreduced sum of num_tables words without overflow.
    function automatic int xpb_sum_bits(input int word_bits, input int num_tables);
        return word_bits + $clog2(num_tables) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/xpb_lut_bank_if.sv
`default_nettype none
// ============================================================================
//  Module   : xpb_lut_bank_if
//  Purpose  : Load-stream, lookup-request and lookup-result signals of the
//             XPB lookup bank.
//  Ports    : master drives clear, wr_valid/wr_data, in_valid/in_idx;
//             slave drives wr_ready, loaded, in_ready, out_valid,
//             out_data, out_sum.
//  Revision : 1.0  initial release
// ============================================================================
interface xpb_lut_bank_if
    import xpb_pkg::*;
#(
    parameter int WORD_BITS  = XPB_WORD_BITS,
    parameter int IDX_BITS   = XPB_IDX_BITS,
    parameter int NUM_TABLES = XPB_NUM_TABLES,
    parameter int SUM_BITS   = xpb_sum_bits(WORD_BITS, NUM_TABLES)
) ();

    logic                             clear;
    logic                             wr_valid;
    logic [WORD_BITS-1:0]             wr_data;
    logic                             wr_ready;
    logic                             loaded;
    logic                             in_valid;
    logic [NUM_TABLES*IDX_BITS-1:0]   in_idx;
    logic                             in_ready;
    logic                             out_valid;
    logic [NUM_TABLES*WORD_BITS-1:0]  out_data;
    logic [SUM_BITS-1:0]              out_sum;

    modport master (
        output clear, wr_valid, wr_data, in_valid, in_idx,
        input  wr_ready, loaded, in_ready, out_valid, out_data, out_sum
    );

    modport slave (
        input  clear, wr_valid, wr_data, in_valid, in_idx,
        output wr_ready, loaded, in_ready, out_valid, out_data, out_sum
    );

endinterface
`default_nettype wire

// File: rtl/xpb_lut_ram.sv
`default_nettype none
// ============================================================================
//  Module   : xpb_lut_ram
//  Purpose  : One simple dual-port table, WORD_BITS x 2^IDX_BITS, with a
//             write port and a registered read port. Contents not reset.
//  Ports    : clk; wr_en/wr_addr/wr_data (write); rd_en/rd_addr (read
//             request); rd_data (registered read data, holds when !rd_en).
//  Revision : 1.0  initial release
// ============================================================================
module xpb_lut_ram #(
    parameter int WORD_BITS = 16,
    parameter int IDX_BITS  = 2
) (
    input  wire logic                 clk,
    input  wire logic                 wr_en,
    input  wire logic [IDX_BITS-1:0]  wr_addr,
    input  wire logic [WORD_BITS-1:0] wr_data,
    input  wire logic                 rd_en,
    input  wire logic [IDX_BITS-1:0]  rd_addr,
    output logic      [WORD_BITS-1:0] rd_data
);

    localparam int C_DEPTH = 1 << IDX_BITS;

    logic [WORD_BITS-1:0] mem_q [C_DEPTH];
    logic [WORD_BITS-1:0] rd_data_q;

    // No reset so the array maps onto block/distributed RAM.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
        if (rd_en) begin
            rd_data_q <= mem_q[rd_addr];
        end
    end

    assign rd_data = rd_data_q;

endmodule
`default_nettype wire

// File: rtl/xpb_lut_bank.sv
`default_nettype none
// ============================================================================
//  Module   : xpb_lut_bank
//  Purpose  : NUM_TABLES runtime-loadable XPB tables. Serial table-major
//             load, then one lookup per table per cycle with a fixed
//             2-cycle latency, plus the unreduced sum of the selected words.
//  Ports    : clk, rst (async, active high);
//             bus (slave): clear, wr_valid/wr_data/wr_ready, loaded,
//             in_valid/in_idx/in_ready, out_valid/out_data/out_sum.
//  Revision : 1.0  initial release
// ============================================================================
module xpb_lut_bank
    import xpb_pkg::*;
#(
    parameter int WORD_BITS  = XPB_WORD_BITS,
    parameter int IDX_BITS   = XPB_IDX_BITS,
    parameter int NUM_TABLES = XPB_NUM_TABLES,
    parameter int SUM_BITS   = xpb_sum_bits(WORD_BITS, NUM_TABLES)
) (
    input  wire logic       clk,
    input  wire logic       rst,
    xpb_lut_bank_if.slave   bus
);

    localparam int C_DEPTH    = 1 << IDX_BITS;
    localparam int C_CNT_BITS = $clog2(NUM_TABLES) + IDX_BITS;
    localparam logic [C_CNT_BITS-1:0] C_CNT_LAST = C_CNT_BITS'(NUM_TABLES * C_DEPTH - 1);

    xpb_state_t                      state_q, state_d;
    logic [C_CNT_BITS-1:0]           cnt_q, cnt_d;
    logic                            s1_valid_q, s1_valid_d;
    logic                            out_valid_q, out_valid_d;
    logic [NUM_TABLES*WORD_BITS-1:0] out_data_q, out_data_d;
    logic [SUM_BITS-1:0]             out_sum_q, out_sum_d;

    logic [NUM_TABLES*WORD_BITS-1:0] w_rd_data;
    logic [SUM_BITS-1:0]             w_sum;
    logic                            w_wr_fire;
    logic                            w_in_fire;

    // clear has priority: a write presented together with clear is dropped.
    assign w_wr_fire = bus.wr_valid && (state_q == ST_LOAD) && !bus.clear;
    assign w_in_fire = bus.in_valid && (state_q == ST_READY);

    generate
        for (genvar t = 0; t < NUM_TABLES; t++) begin : g_table
            logic w_wr_en;

            // Upper counter bits select the table being filled.
            assign w_wr_en = w_wr_fire && ((cnt_q >> IDX_BITS) == C_CNT_BITS'(t));

            xpb_lut_ram #(
                .WORD_BITS (WORD_BITS),
                .IDX_BITS  (IDX_BITS)
            ) u_ram (
                .clk     (clk),
                .wr_en   (w_wr_en),
                .wr_addr (cnt_q[IDX_BITS-1:0]),
                .wr_data (bus.wr_data),
                .rd_en   (w_in_fire),
                .rd_addr (bus.in_idx[t*IDX_BITS +: IDX_BITS]),
                .rd_data (w_rd_data[t*WORD_BITS +: WORD_BITS])
            );
        end
    endgenerate

    // Sum of the stage-1 read words, zero-extended; registered in stage 2.
    always_comb begin
        w_sum = '0;
        for (int t = 0; t < NUM_TABLES; t++) begin
            w_sum = w_sum + SUM_BITS'(w_rd_data[t*WORD_BITS +: WORD_BITS]);
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        s1_valid_d  = w_in_fire;
        out_valid_d = s1_valid_q;
        out_data_d  = out_data_q;
        out_sum_d   = out_sum_q;

        if (s1_valid_q) begin
            out_data_d = w_rd_data;
            out_sum_d  = w_sum;
        end

        if (bus.clear) begin
            state_d = ST_LOAD;
            cnt_d   = '0;
        end else if (w_wr_fire) begin
            if (cnt_q == C_CNT_LAST) begin
                state_d = ST_READY;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + C_CNT_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_LOAD;
            cnt_q       <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sum_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sum_q   <= out_sum_d;
        end
    end

    assign bus.wr_ready  = (state_q == ST_LOAD);
    assign bus.loaded    = (state_q == ST_READY);
    assign bus.in_ready  = (state_q == ST_READY);
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sum   = out_sum_q;

endmodule
`default_nettype wire

// File: tb/tb_xpb_lut_bank.sv
`default_nettype none
// ============================================================================
//  Module   : tb_xpb_lut_bank
//  Purpose  : Self-checking bench for xpb_lut_bank (16-bit words, 2 tables
//             of 4 entries). A reference model tracks the loaded contents
//             and expected lookup results; directed scenarios add literal
//             expectations.
//  Ports    : none
//  Revision : 1.0  initial release
// ============================================================================
module tb_xpb_lut_bank;

    localparam int WB    = 16;
    localparam int IB    = 2;
    localparam int NT    = 2;
    localparam int SB    = 18;
    localparam int DEPTH = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    xpb_lut_bank_if #(.WORD_BITS(WB), .IDX_BITS(IB), .NUM_TABLES(NT)) bus ();

    xpb_lut_bank #(
        .WORD_BITS  (WB),
        .IDX_BITS   (IB),
        .NUM_TABLES (NT)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int                 due;
        logic [NT*WB-1:0]   data;
        logic [SB-1:0]      sum;
    } exp_t;

    exp_t          exp_q[$];
    logic [WB-1:0] m_mem [NT*DEPTH];
    bit            m_loaded = 1'b0;
    int            m_cnt    = 0;
    int            cyc      = 0;

    initial begin
        exp_t e;
        int   idx;
        forever begin
            @(posedge clk);
            cyc++;
            if (rst) begin
                m_loaded = 1'b0;
                m_cnt    = 0;
                exp_q.delete();
            end else begin
                if (bus.in_valid && m_loaded) begin
                    e.due = cyc + 1;
                    e.sum = '0;
                    for (int t = 0; t < NT; t++) begin
                        idx = int'((bus.in_idx >> (t*IB)) & 4'h3);
                        e.data[t*WB +: WB] = m_mem[t*DEPTH + idx];
                        e.sum = e.sum + SB'(m_mem[t*DEPTH + idx]);
                    end
                    exp_q.push_back(e);
                end
                if (bus.clear) begin
                    m_loaded = 1'b0;
                    m_cnt    = 0;
                end else if (bus.wr_valid && !m_loaded) begin
                    m_mem[m_cnt] = bus.wr_data;
                    m_cnt++;
                    if (m_cnt == NT*DEPTH) begin
                        m_loaded = 1'b1;
                        m_cnt    = 0;
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                chk("rst_loaded", bus.loaded, 0);
                chk("rst_out_valid", bus.out_valid, 0);
                chk("rst_wr_ready", bus.wr_ready, 1);
            end else begin
                chk("loaded", bus.loaded, m_loaded);
                chk("in_ready", bus.in_ready, m_loaded);
                chk("wr_ready", bus.wr_ready, !m_loaded);
                if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                    chk("out_valid", bus.out_valid, 1);
                    chk("out_data", bus.out_data, exp_q[0].data);
                    chk("out_sum", bus.out_sum, exp_q[0].sum);
                    void'(exp_q.pop_front());
                end else begin
                    chk("out_valid_idle", bus.out_valid, 0);
                end
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic load_words(input logic [WB-1:0] base, input bit inc);
        for (int i = 0; i < NT*DEPTH; i++) begin
            @(negedge clk);
            bus.wr_valid = 1'b1;
            bus.wr_data  = inc ? base + WB'(i) : base;
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
    endtask

    task automatic lookup(input logic [NT*IB-1:0] idx, input logic [NT*WB-1:0] edata,
                          input logic [SB-1:0] esum, input string name);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_idx   = idx;
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk({name, "_lat1"}, bus.out_valid, 0);
        @(negedge clk);
        chk({name, "_valid"}, bus.out_valid, 1);
        chk({name, "_data"}, bus.out_data, edata);
        chk({name, "_sum"}, bus.out_sum, esum);
    endtask

    logic [SB-1:0] stream_sum [4] = '{18'h00206, 18'h00208, 18'h0020A, 18'h0020C};
    logic [1:0]    sidx;

    initial begin
        int nvalid;
        bus.clear    = 1'b0;
        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.in_valid = 1'b0;
        bus.in_idx   = '0;

        repeat (3) @(negedge clk);
        chk("reset_wr_ready", bus.wr_ready, 1);
        chk("reset_loaded", bus.loaded, 0);
        chk("reset_out_valid", bus.out_valid, 0);
        chk("reset_out_data", bus.out_data, 0);
        chk("reset_out_sum", bus.out_sum, 0);
        rst = 1'b0;

        // Request before load must be dropped.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_idx   = '0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        nvalid = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.out_valid) nvalid++;
        end
        chk("preload_no_valid", nvalid, 0);

        // Load 0x0101..0x0108.
        load_words(16'h0101, 1'b1);
        chk("load_done_loaded", bus.loaded, 1);
        chk("load_done_wr_ready", bus.wr_ready, 0);

        lookup({2'd2, 2'd3}, 32'h0107_0104, 18'h0020B, "lk1");

        // Writes while READY are ignored.
        @(negedge clk);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'hDEAD;
        repeat (3) @(negedge clk);
        bus.wr_valid = 1'b0;
        lookup({2'd2, 2'd3}, 32'h0107_0104, 18'h0020B, "lk_after_wr");

        // Streaming: back-to-back requests, back-to-back results.
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (n >= 2) begin
                chk("stream_valid", bus.out_valid, 1);
                chk("stream_sum", bus.out_sum, stream_sum[n-2]);
            end
            if (n < 4) begin
                sidx         = 2'(n);
                bus.in_valid = 1'b1;
                bus.in_idx   = {sidx, sidx};
            end else begin
                bus.in_valid = 1'b0;
            end
        end

        // Clear, start a reload, clear again together with a write, reload with 0xFFFF.
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear = 1'b0;
        chk("clear_loaded", bus.loaded, 0);
        chk("clear_wr_ready", bus.wr_ready, 1);
        bus.wr_valid = 1'b1;
        bus.wr_data  = 16'h5555;
        @(negedge clk);
        bus.clear = 1'b1;
        @(negedge clk);
        bus.clear    = 1'b0;
        bus.wr_valid = 1'b0;
        load_words(16'hFFFF, 1'b0);
        lookup({2'd3, 2'd0}, 32'hFFFF_FFFF, 18'h1FFFE, "lk_overflow");

        // Asynchronous reset with a result on the output.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_idx   = '0;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("pre_rst_valid", bus.out_valid, 1);
        #1 rst = 1'b1;
        #1;
        chk("async_loaded", bus.loaded, 0);
        chk("async_out_valid", bus.out_valid, 0);
        chk("async_out_sum", bus.out_sum, 0);
        chk("async_wr_ready", bus.wr_ready, 1);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("post_rst_wr_ready", bus.wr_ready, 1);

        // Reset in the middle of a reload, then a full load restarts at entry 0.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.wr_valid = 1'b1;
            bus.wr_data  = 16'h0AAA;
        end
        @(negedge clk);
        bus.wr_valid = 1'b0;
        #2 rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        load_words(16'h0201, 1'b1);
        lookup({2'd0, 2'd0}, 32'h0205_0201, 18'h00406, "lk_reload0");
        lookup({2'd3, 2'd3}, 32'h0208_0204, 18'h0040C, "lk_reload3");

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
